// File: rtl/controle_servo_multi.sv
// Multi-channel hobby-servo PWM generator.
// A single period counter is shared by all channels. Each channel holds a
// target width (alvo) and a current width (atual) that slews toward the
// target once per period. Inputs are sampled only on the last cycle of a
// period, so a pulse already in progress never changes shape.
module controle_servo_multi #(
  parameter int N_CANAIS       = 4,
  parameter int W_POS          = 8,
  parameter int CONF_PERIODO   = 1_000_000,
  parameter int LARGURA_MIN    = 50_000,
  parameter int LARGURA_MAX    = 100_000,
  parameter int LARGURA_CENTRO = 75_000,
  parameter int PASSO          = 1_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_CANAIS*W_POS-1:0] posicao,
  input  logic [N_CANAIS-1:0]       habilita,
  output logic [N_CANAIS-1:0]       controle,
  output logic [N_CANAIS-1:0]       db_controle,
  output logic [N_CANAIS-1:0]       pronto,
  output logic                      inicio_periodo
);

  localparam int W_CNT  = (CONF_PERIODO > 1) ? $clog2(CONF_PERIODO) : 1;
  localparam int W_PROD = W_POS + W_CNT;

  localparam logic [W_CNT-1:0] C_ULTIMO = W_CNT'(CONF_PERIODO - 1);
  localparam logic [W_CNT-1:0] C_MIN    = W_CNT'(LARGURA_MIN);
  localparam logic [W_CNT-1:0] C_MAX    = W_CNT'(LARGURA_MAX);
  localparam logic [W_CNT-1:0] C_CENTRO = W_CNT'(LARGURA_CENTRO);
  localparam logic [W_CNT-1:0] C_FAIXA  = W_CNT'(LARGURA_MAX - LARGURA_MIN);

  // A step at least as large as the period can never limit anything, so it
  // behaves exactly like "no slew limit" and keeps C_PASSO within W_CNT bits.
  localparam bit               PASSO_LIVRE = (PASSO == 0) || (PASSO >= CONF_PERIODO);
  localparam logic [W_CNT-1:0] C_PASSO     = W_CNT'(PASSO_LIVRE ? 0 : PASSO);

  localparam logic [W_POS-1:0] C_CODIGO_MAX = '1;

  logic [W_CNT-1:0] r_contador;
  logic             w_fim_periodo;

  assign w_fim_periodo  = (r_contador == C_ULTIMO);
  assign inicio_periodo = ~reset & (r_contador == '0);

  // Shared period counter: 0 .. CONF_PERIODO-1, then wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contador <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop sees pre-edge values.
      r_contador <= w_fim_periodo ? '0 : r_contador + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
    logic [W_POS-1:0]  w_codigo;
    logic [W_PROD-1:0] w_prod;
    logic [W_CNT-1:0]  w_alvo_novo;
    logic [W_CNT-1:0]  w_diff;
    logic [W_CNT-1:0]  w_atual_novo;
    logic [W_CNT-1:0]  r_atual;
    logic [W_CNT-1:0]  r_alvo;
    logic              r_hab;

    assign w_codigo = posicao[g*W_POS +: W_POS];

    // Code-to-width mapping; the product is kept at full width before the shift.
    assign w_prod      = W_PROD'(w_codigo) * W_PROD'(C_FAIXA);
    assign w_alvo_novo = (w_codigo == C_CODIGO_MAX) ? C_MAX
                                                    : C_MIN + W_CNT'(w_prod >> W_POS);

    // Slew limiter: step toward the new target, landing on it when within one step.
    always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      w_atual_novo = w_alvo_novo;
      w_diff       = '0;
      if (w_alvo_novo > r_atual) begin
        w_diff = w_alvo_novo - r_atual;
        if (!PASSO_LIVRE && (w_diff > C_PASSO)) w_atual_novo = r_atual + C_PASSO;
      end else begin
        w_diff = r_atual - w_alvo_novo;
        if (!PASSO_LIVRE && (w_diff > C_PASSO)) w_atual_novo = r_atual - C_PASSO;
      end
    end

    // Per-channel state, updated only on the last cycle of each period.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_atual <= C_CENTRO;
        r_alvo  <= C_CENTRO;
        r_hab   <= 1'b0;
      end else if (w_fim_periodo) begin
        r_atual <= w_atual_novo;
        r_alvo  <= w_alvo_novo;
        r_hab   <= habilita[g];
      end
    end

    assign controle[g] = r_hab & (r_contador < r_atual);
    assign pronto[g]   = (r_atual == r_alvo);
  end

  assign db_controle = controle;

endmodule

// File: tb/tb_controle_servo_multi.sv
// Bench for controle_servo_multi: two instances (slew-limited and PASSO=0)
// driven by the same stimulus and compared each cycle against a
// period-level reference model.
module tb_controle_servo_multi;

  localparam int N    = 2;
  localparam int W    = 2;
  localparam int P    = 100;
  localparam int LMIN = 10;
  localparam int LMAX = 20;
  localparam int LC   = 15;
  localparam int PS   = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N*W-1:0]   posicao;
  logic [N-1:0]     habilita;
  logic [N-1:0]     controle_a, db_a, pronto_a;
  logic [N-1:0]     controle_b, db_b, pronto_b;
  logic             ini_a, ini_b;

  always #5 clock = ~clock;

  controle_servo_multi #(
    .N_CANAIS(N), .W_POS(W), .CONF_PERIODO(P), .LARGURA_MIN(LMIN),
    .LARGURA_MAX(LMAX), .LARGURA_CENTRO(LC), .PASSO(PS)
  ) dut_a (
    .clock(clock), .reset(reset), .posicao(posicao), .habilita(habilita),
    .controle(controle_a), .db_controle(db_a), .pronto(pronto_a),
    .inicio_periodo(ini_a)
  );

  controle_servo_multi #(
    .N_CANAIS(N), .W_POS(W), .CONF_PERIODO(P), .LARGURA_MIN(LMIN),
    .LARGURA_MAX(LMAX), .LARGURA_CENTRO(LC), .PASSO(0)
  ) dut_b (
    .clock(clock), .reset(reset), .posicao(posicao), .habilita(habilita),
    .controle(controle_b), .db_controle(db_b), .pronto(pronto_b),
    .inicio_periodo(ini_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: index 0 = PASSO=PS instance, index 1 = PASSO=0 instance.
  int m_cnt;
  int m_atual [2][N];
  int m_alvo  [2][N];
  bit m_hab   [N];
  int m_passo [2] = '{PS, 0};

  function automatic int map_code(input int code);
    if (code == (1 << W) - 1) return LMAX;
    return LMIN + (code * (LMAX - LMIN)) / (1 << W);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < N; c++) begin
      m_hab[c] = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_atual[d][c] = LC;
        m_alvo[d][c]  = LC;
      end
    end
  endtask

  task automatic model_boundary();
    for (int c = 0; c < N; c++) begin
      int code;
      code     = int'(posicao[c*W +: W]);
      m_hab[c] = habilita[c];
      for (int d = 0; d < 2; d++) begin
        int diff;
        m_alvo[d][c] = map_code(code);
        diff = m_alvo[d][c] - m_atual[d][c];
        if (m_passo[d] == 0 || (diff <= m_passo[d] && diff >= -m_passo[d]))
          m_atual[d][c] = m_alvo[d][c];
        else if (diff > 0)
          m_atual[d][c] = m_atual[d][c] + m_passo[d];
        else
          m_atual[d][c] = m_atual[d][c] - m_passo[d];
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_ctl [2];
    logic [N-1:0] e_rdy [2];
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        e_ctl[d][c] = m_hab[c] && (m_cnt < m_atual[d][c]);
        e_rdy[d][c] = (m_atual[d][c] == m_alvo[d][c]);
      end
    end
    check("controle_a",    controle_a, e_ctl[0]);
    check("db_controle_a", db_a,       e_ctl[0]);
    check("pronto_a",      pronto_a,   e_rdy[0]);
    check("inicio_a",      ini_a,      m_cnt == 0);
    check("controle_b",    controle_b, e_ctl[1]);
    check("db_controle_b", db_b,       e_ctl[1]);
    check("pronto_b",      pronto_b,   e_rdy[1]);
    check("inicio_b",      ini_b,      m_cnt == 0);
  endtask

  // One clock cycle: check, optionally perturb inputs, advance the model.
  task automatic step(input bit rnd);
    check_outputs();
    if (rnd && $urandom_range(0, 39) == 0) begin
      posicao  = (N*W)'($urandom);
      habilita = N'($urandom_range(0, 3) == 0 ? $urandom : 32'hFFFF_FFFF);
    end
    if (m_cnt == P - 1) model_boundary();
    m_cnt = (m_cnt + 1) % P;
    @(negedge clock);
    #1;
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) step(rnd);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_controle_a"}, controle_a, 2'b00);
    check({tag, "_db_a"},       db_a,       2'b00);
    check({tag, "_pronto_a"},   pronto_a,   2'b11);
    check({tag, "_inicio_a"},   ini_a,      1'b0);
    check({tag, "_controle_b"}, controle_b, 2'b00);
    check({tag, "_pronto_b"},   pronto_b,   2'b11);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    posicao  = {2'd2, 2'd2};
    habilita = 2'b11;
    reset    = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_reset_state("rst");

    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();

    // Period 0 low, period 1 at width 15 on both channels.
    run(2 * P, 1'b0);
    check("center_pronto", pronto_a, 2'b11);

    // ch0 to code 3 mid-period: 17, 19, 20, 20 (and 20 at once with PASSO=0).
    run(40, 1'b0);
    posicao = {2'd2, 2'd3};
    run(60 + 4 * P, 1'b0);
    check("max_pronto_a", pronto_a, 2'b11);

    // ch0 down to code 0: 18 .. 10, then code 1 gives 12.
    run(30, 1'b0);
    posicao = {2'd2, 2'd0};
    run(70 + 6 * P, 1'b0);
    posicao = {2'd2, 2'd1};
    run(3 * P, 1'b0);

    // Drop habilita[1] while its pulse is high, then re-enable.
    run(5, 1'b0);
    habilita = 2'b01;
    posicao  = {2'd0, 2'd1};
    run(95 + 2 * P, 1'b0);
    habilita = 2'b11;
    run(2 * P, 1'b0);

    // Randomized traffic.
    run(10 * P, 1'b1);

    // Reset asserted while pulses are high at contador == 7.
    posicao  = {2'd2, 2'd3};
    habilita = 2'b11;
    run(P, 1'b0);
    while (m_cnt != 7) step(1'b0);
    check("pre_reset_high", controle_a, 2'b11);
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    check("inicio_after_rst", ini_a, 1'b1);
    run(2 * P, 1'b0);
    run(5 * P, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_servo_multi.md
CONTROLE_SERVO_MULTI -- requirements
Module: controle_servo_multi

Interface
REQ-001 The block SHALL have parameter N_CANAIS, default 4, number of independent servo channels (1..16).
REQ-002 The block SHALL have parameter W_POS, default 8, position code width per channel (1..12).
REQ-003 The block SHALL have parameter CONF_PERIODO, default 1_000_000, PWM period in clock cycles.
REQ-004 The block SHALL have parameter LARGURA_MIN, default 50_000, pulse width in cycles for position 0.
REQ-005 The block SHALL have parameter LARGURA_MAX, default 100_000, pulse width in cycles for position all-ones.
REQ-006 The block SHALL have parameter LARGURA_CENTRO, default 75_000, pulse width loaded at reset.
REQ-007 The block SHALL have parameter PASSO, default 1_000, maximum width change per period; 0 means no slew limit.
REQ-008 The block SHALL have port clock, input, 1 bit, single clock for all logic.
REQ-009 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-010 The block SHALL have port posicao, input, N_CANAIS*W_POS bits, channel i target code in bits [i*W_POS +: W_POS].
REQ-011 The block SHALL have port habilita, input, N_CANAIS bits, per-channel output enable.
REQ-012 The block SHALL have port controle, output, N_CANAIS bits, per-channel PWM to servo.
REQ-013 The block SHALL have port db_controle, output, N_CANAIS bits, debug copy of controle.
REQ-014 The block SHALL have port pronto, output, N_CANAIS bits, high when channel current width equals target width.
REQ-015 The block SHALL have port inicio_periodo, output, 1 bit, one-cycle pulse while the counter equals 0.

Function
REQ-016 Counter: contador SHALL count 0..CONF_PERIODO-1 and then wrap to 0, advancing by 1 every clock; its width SHALL be clog2(CONF_PERIODO).
REQ-017 Boundary: on the cycle contador==CONF_PERIODO-1, the block SHALL sample posicao and habilita into registers alvo_i and hab_reg_i; no other sampling SHALL occur.
REQ-018 Mapping: alvo_i SHALL be LARGURA_MAX when the code is all-ones, else LARGURA_MIN + ((code*(LARGURA_MAX-LARGURA_MIN)) >> W_POS), computed with full-width intermediate (no truncation).
REQ-019 Slew: on the same boundary cycle, atual_i SHALL move toward the new alvo_i by min(PASSO, |alvo_i-atual_i|); PASSO=0 SHALL set atual_i=alvo_i directly.
REQ-020 Slew arithmetic SHALL be computed without overshoot or wrap; atual_i SHALL stay within [LARGURA_MIN, LARGURA_MAX] once it has left LARGURA_CENTRO.
REQ-021 Output: controle[i] SHALL equal hab_reg_i AND (contador < atual_i), derived only from registered operands.
REQ-022 Timing: the new atual_i and hab_reg_i SHALL take effect at contador==0 of the following period, so a posicao change reaches the output within at most 2 periods.
REQ-023 db_controle SHALL equal controle bit for bit.
REQ-024 pronto[i] SHALL equal (atual_i == alvo_i), updated with atual_i.
REQ-025 Independence: channels SHALL share only contador; a change on one channel SHALL NOT alter any other channel's output.
REQ-026 A habilita drop SHALL force the channel low from the next period start, while atual_i keeps slewing.
REQ-027 A posicao change mid-period SHALL NOT affect the current pulse.
REQ-028 The block SHALL require LARGURA_MIN <= LARGURA_CENTRO <= LARGURA_MAX < CONF_PERIODO; behaviour outside this range is undefined.

Reset
REQ-029 While reset is high, the block SHALL hold contador=0, atual_i=alvo_i=LARGURA_CENTRO, hab_reg=0, controle=db_controle=0, and pronto=all-ones.
REQ-030 inicio_periodo SHALL be 0 during reset and 1 on the first clock after release.
REQ-031 Reset asserted mid-period SHALL abort the pulse immediately and asynchronously, and SHALL restart the period from 0 on release.

Verification
(Bench parameters: N_CANAIS=2, W_POS=2, CONF_PERIODO=100, MIN=10, MAX=20, CENTRO=15, PASSO=2.)
REQ-032 Scenario: release reset with habilita=11 and posicao=ch1:2, ch0:2 -> period 0 both outputs low; from period 1 both outputs high for 15 cycles of each 100; pronto=11.
REQ-033 Scenario: ch0 code 3 applied during period 1 -> ch0 widths in successive periods 17, 19, 20, 20; pronto[0]=0 until width reaches 20; ch1 stays at 15.
REQ-034 Scenario: ch0 code 0 starting from width 20 -> widths 18, 16, 14, 12, 10; code 1 then gives 12.
REQ-035 Scenario: habilita[1]=0 mid-period -> current pulse completes; from the next period controle[1]=0; re-enable restores the pulse at the tracked width.
REQ-036 Scenario: PASSO=0 build, code 0 to 3 -> next period width 20 directly, with pronto=1.
REQ-037 Scenario: reset pulse at contador=7 during a high pulse -> controle drops asynchronously; after release, width returns to 15 and inicio_periodo pulses on the first cycle.
